// File: rtl/mux4_pkg.sv
// Shared select encodings and types for the registered 4:1 selector.
package mux4_pkg;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  typedef logic [1:0] sel_t;

endpackage

// File: rtl/mux4_pipe_if.sv
// Source/result bundle of mux4_pipe. Valid-only handshake: in_valid qualifies a..d/s0/s1
// in the cycle it is high, out_valid qualifies out/sel_q; there is no ready/backpressure.
interface mux4_pipe_if
  import mux4_pkg::*;
#(
  parameter int WIDTH = 1
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  sel_t             sel_q;

  modport master (
    output in_valid, a, b, c, d, s0, s1,
    input  out, out_valid, sel_q
  );

  modport slave (
    input  in_valid, a, b, c, d, s0, s1,
    output out, out_valid, sel_q
  );

endinterface

// File: rtl/mux4_comb.sv
// Purely combinational WIDTH-bit 4:1 select.
module mux4_comb
  import mux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mux4_pipe.sv
// Registered 4:1 selector: combinational select followed by a LATENCY-deep
// pipeline of {data, sel, valid}; outputs come straight from the last stage.
module mux4_pipe
  import mux4_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input logic        clk,
  input logic        rst_n,
  mux4_pipe_if.slave bus
);

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("mux4_pipe: LATENCY must be in 1..4");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("mux4_pipe: WIDTH must be in 1..64");
    end
  endgenerate

  sel_t             sel;
  logic [WIDTH-1:0] y;

  assign sel = {bus.s1, bus.s0};

  mux4_comb #(.WIDTH(WIDTH)) u_comb (
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .d   (bus.d),
    .sel (sel),
    .y   (y)
  );

  logic [WIDTH-1:0] data_r [LATENCY];
  sel_t             sel_r  [LATENCY];
  logic             vld_r  [LATENCY];

  // Stage 0 holds data/sel across bubbles; later stages shift every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        data_r[i] <= '0;
        sel_r[i]  <= SEL_A;
        vld_r[i]  <= 1'b0;
      end
    end else begin
      vld_r[0] <= bus.in_valid;
      if (bus.in_valid) begin
        data_r[0] <= y;
        sel_r[0]  <= sel;
      end
      for (int i = 1; i < LATENCY; i++) begin
        data_r[i] <= data_r[i-1];
        sel_r[i]  <= sel_r[i-1];
        vld_r[i]  <= vld_r[i-1];
      end
    end
  end

  assign bus.out       = data_r[LATENCY-1];
  assign bus.sel_q     = sel_r[LATENCY-1];
  assign bus.out_valid = vld_r[LATENCY-1];

endmodule

// File: tb/tb_mux4_pipe.sv
// Bench for mux4_pipe: three configurations (W1/L1, W8/L3, W8/L4) on one clock.
module tb_mux4_pipe;
  import mux4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux4_pipe_if #(.WIDTH(1)) i1 ();
  mux4_pipe_if #(.WIDTH(8)) i3 ();
  mux4_pipe_if #(.WIDTH(8)) i4 ();

  mux4_pipe #(.WIDTH(1), .LATENCY(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
  mux4_pipe #(.WIDTH(8), .LATENCY(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));
  mux4_pipe #(.WIDTH(8), .LATENCY(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));

  // Illegal-input guard: selects must be known whenever they are qualified.
  always @(posedge clk) begin
    if (rst_n && i1.in_valid) assert (!$isunknown({i1.s1, i1.s0})) else $error("X select on i1");
    if (rst_n && i3.in_valid) assert (!$isunknown({i3.s1, i3.s0})) else $error("X select on i3");
    if (rst_n && i4.in_valid) assert (!$isunknown({i4.s1, i4.s0})) else $error("X select on i4");
  end

  int checks   = 0;
  int failures = 0;

  // ---------------- driver tasks ----------------
  task automatic drv(input int which, input logic v, input logic [1:0] sel,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] d);
    case (which)
      1: begin
        i1.in_valid = v; i1.s1 = sel[1]; i1.s0 = sel[0];
        i1.a = a[0]; i1.b = b[0]; i1.c = c[0]; i1.d = d[0];
      end
      3: begin
        i3.in_valid = v; i3.s1 = sel[1]; i3.s0 = sel[0];
        i3.a = a; i3.b = b; i3.c = c; i3.d = d;
      end
      default: begin
        i4.in_valid = v; i4.s1 = sel[1]; i4.s0 = sel[0];
        i4.a = a; i4.b = b; i4.c = c; i4.d = d;
      end
    endcase
  endtask

  task automatic drv_rand(input int which);
    drv(which, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
        8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
        8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " dut1 out"},       64'(i1.out),       64'd0);
    chk({tag, " dut1 sel_q"},     64'(i1.sel_q),     64'd0);
    chk({tag, " dut1 out_valid"}, 64'(i1.out_valid), 64'd0);
    chk({tag, " dut3 out"},       64'(i3.out),       64'd0);
    chk({tag, " dut3 out_valid"}, 64'(i3.out_valid), 64'd0);
    chk({tag, " dut4 out"},       64'(i4.out),       64'd0);
    chk({tag, " dut4 sel_q"},     64'(i4.sel_q),     64'd0);
    chk({tag, " dut4 out_valid"}, 64'(i4.out_valid), 64'd0);
  endtask

  // Reference select for the scoreboard.
  function automatic logic [7:0] ref_sel(input logic [1:0] s, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c,
                                         input logic [7:0] d);
    case (s)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return d;
    endcase
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] sel;
    logic [3:0] dcba;
    logic       exp;
  } vec_t;

  vec_t tbl[8];
  logic [9:0] exp_q[$];

  initial begin
    tbl[0] = '{2'b00, 4'b0101, 1'b1};
    tbl[1] = '{2'b01, 4'b0101, 1'b0};
    tbl[2] = '{2'b10, 4'b0101, 1'b1};
    tbl[3] = '{2'b11, 4'b0101, 1'b0};
    tbl[4] = '{2'b00, 4'b1010, 1'b0};
    tbl[5] = '{2'b01, 4'b1010, 1'b1};
    tbl[6] = '{2'b10, 4'b1010, 1'b0};
    tbl[7] = '{2'b11, 4'b1010, 1'b1};

    rst_n = 1'b0;
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(3, 0, 0, 0, 0, 0, 0);
    drv(4, 0, 0, 0, 0, 0, 0);

    // Reset held with toggling inputs.
    repeat (5) begin
      @(negedge clk);
      chk_zero("rst_hold");
      drv_rand(1); drv_rand(3); drv_rand(4);
    end
    @(negedge clk);
    chk_zero("rst_hold_end");
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(3, 0, 0, 0, 0, 0, 0);
    drv(4, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Select sweep on W1/L1, back to back.
    for (int i = 0; i < 8; i++) begin
      drv(1, 1, tbl[i].sel, 8'(tbl[i].dcba[0]), 8'(tbl[i].dcba[1]),
          8'(tbl[i].dcba[2]), 8'(tbl[i].dcba[3]));
      @(negedge clk);
      chk($sformatf("sweep%0d out", i),   64'(i1.out),       64'(tbl[i].exp));
      chk($sformatf("sweep%0d sel_q", i), 64'(i1.sel_q),     64'(tbl[i].sel));
      chk($sformatf("sweep%0d vld", i),   64'(i1.out_valid), 64'd1);
    end

    // Bubble hold: valid d=1, then a bubble with a=0 selected.
    drv(1, 1, 2'b11, 8'd0, 8'd0, 8'd0, 8'd1);
    @(negedge clk);
    chk("bubble pre out", 64'(i1.out), 64'd1);
    chk("bubble pre vld", 64'(i1.out_valid), 64'd1);
    drv(1, 0, 2'b00, 8'd0, 8'd1, 8'd1, 8'd1);
    repeat (2) begin
      @(negedge clk);
      chk("bubble out",   64'(i1.out),       64'd1);
      chk("bubble sel_q", 64'(i1.sel_q),     64'd3);
      chk("bubble vld",   64'(i1.out_valid), 64'd0);
    end

    // Latency on W8/L3: single pulse, valid only on the third edge.
    drv(3, 1, 2'b10, 8'h11, 8'h22, 8'h33, 8'h44);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) drv(3, 0, 2'b00, 8'h11, 8'h22, 8'h33, 8'h44);
      chk($sformatf("lat3 vld k=%0d", k), 64'(i3.out_valid), 64'(k == 3));
      if (k == 3) begin
        chk("lat3 out",   64'(i3.out),   64'h33);
        chk("lat3 sel_q", 64'(i3.sel_q), 64'd2);
      end
    end

    // Random regression on W8/L3 with scoreboard.
    for (int k = 0; k < 100 + 3; k++) begin
      if (k >= 3) begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("rand out",   64'(i3.out),       64'(e[7:0]));
        chk("rand sel_q", 64'(i3.sel_q),     64'(e[9:8]));
        chk("rand vld",   64'(i3.out_valid), 64'd1);
      end
      if (k < 100) begin
        logic [1:0] s;
        logic [7:0] a, b, c, d;
        s = 2'($urandom_range(0, 3));
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        c = 8'($urandom_range(0, 255)); d = 8'($urandom_range(0, 255));
        drv(3, 1, s, a, b, c, d);
        exp_q.push_back({s, ref_sel(s, a, b, c, d)});
      end else begin
        drv(3, 0, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
      end
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    drv(1, 1, 2'b11, 8'd0, 8'd0, 8'd0, 8'd1);
    drv(4, 1, 2'b01, 8'h00, 8'h5A, 8'h00, 8'h00);
    repeat (5) @(negedge clk);
    chk("fill dut1 vld", 64'(i1.out_valid), 64'd1);
    chk("fill dut4 out", 64'(i4.out),       64'h5A);
    chk("fill dut4 vld", 64'(i4.out_valid), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(4, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Reset pulse mid-stream on a full L4 pipeline.
    drv(4, 1, 2'b11, 8'h00, 8'h00, 8'h00, 8'hC3);
    repeat (5) @(negedge clk);
    chk("full4 out", 64'(i4.out),       64'hC3);
    chk("full4 vld", 64'(i4.out_valid), 64'd1);
    drv(4, 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    chk("pulse dut4 vld", 64'(i4.out_valid), 64'd0);
    chk("pulse dut4 out", 64'(i4.out),       64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("post pulse idle vld", 64'(i4.out_valid), 64'd0);
    end
    drv(4, 1, 2'b10, 8'h00, 8'h00, 8'h77, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) drv(4, 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
      chk($sformatf("restart4 vld k=%0d", k), 64'(i4.out_valid), 64'(k == 4));
      if (k == 4) begin
        chk("restart4 out",   64'(i4.out),   64'h77);
        chk("restart4 sel_q", 64'(i4.sel_q), 64'd2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_pipe.md
Name: mux4_pipe

Overview:
- Registered 4:1 selector: one of four WIDTH-bit sources (a, b, c, d) is chosen by the two select bits {s1,s0} and presented on out after a fixed pipeline latency.
- Used as a generic datapath steering element where a registered, valid-qualified output is needed.
- Default configuration (WIDTH=1, LATENCY=1) is a single-bit 4:1 mux with one register stage.

Parameters:
- WIDTH, 1, bit width of a, b, c, d and out; legal range 1..64.
- LATENCY, 1, number of register stages from inputs to out; legal range 1..4. Any other value is rejected at elaboration with $error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a, b, c, d, s0 and s1 in the current cycle.
- a  input  WIDTH  source 0.
- b  input  WIDTH  source 1.
- c  input  WIDTH  source 2.
- d  input  WIDTH  source 3.
- s0  input  1  select LSB.
- s1  input  1  select MSB.
- out  output  WIDTH  selected data, registered.
- out_valid  output  1  out carries a valid result.
- sel_q  output  2  the {s1,s0} value that produced the current out.

Behaviour:
- Select map for sel={s1,s0}: 2'b00 selects a, 2'b01 selects b, 2'b10 selects c, 2'b11 selects d.
- Combinational select feeds a LATENCY-deep pipeline. Each stage holds data, sel and valid.
- Latency is exactly LATENCY clk edges from a sampled input to out, sel_q and out_valid.
- Stage 1 on each rising clk edge:
  - If in_valid=1, it loads the mux result and sel, and sets valid=1.
  - If in_valid=0, its data and sel keep their previous values and valid=0 (bubble).
- Stages 2..LATENCY shift unconditionally every edge; data, sel and valid all advance together.
- out, sel_q and out_valid are driven directly from the last stage. There is no combinational path from any input to any output.
- Reset (rst_n=0) asynchronously clears every stage: out=0, sel_q=2'b00, out_valid=0.
  - Reset mid-stream discards all in-flight data.
  - On the first rising edge after rst_n deasserts, stage 1 samples normally.
- A select change takes effect on the next sampled input. No glitch or partial value is ever visible on out.
- Back-to-back in_valid=1 gives one result per cycle (full throughput); there is no backpressure.
- If in_valid and reset are active together, reset wins.
- X/Z on s0/s1 while in_valid=1 is an illegal input. The bench asserts against it; RTL behaviour in that case is unspecified.

Decomposition:
- Shared package mux4_pkg holds:
  - localparam SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - typedef logic [1:0] sel_t.
- One sub-module, mux4_comb: purely combinational WIDTH-parameterised 4:1 select (inputs a..d and sel_t sel, output y).
- mux4_pipe instantiates mux4_comb once and generates the LATENCY register stages.

Test Plan:
- Reset:
  - Hold rst_n=0 with random inputs toggling → out=0, sel_q=0, out_valid=0 throughout.
  - Assert rst_n=0 asynchronously mid-cycle → outputs clear immediately, without waiting for a clock edge.
- Select sweep (WIDTH=1, LATENCY=1):
  - Stimulus: a=1, b=0, c=1, d=0, in_valid=1; sel stepped 00, 01, 10, 11 on consecutive cycles.
  - Response: out is 1, 0, 1, 0, each one cycle after its select; sel_q follows the select; out_valid=1.
- Latency (WIDTH=8, LATENCY=3):
  - Stimulus: a=8'h11, b=8'h22, c=8'h33, d=8'h44, sel=2'b10, in_valid pulsed for one cycle.
  - Response: out=8'h33 and out_valid=1 exactly 3 edges later for one cycle; out_valid=0 before and after.
- Bubble hold:
  - Stimulus: in_valid=1 with sel=11, d=1, then in_valid=0 while sel=00 and a=0.
  - Response: out stays 1 and out_valid drops to 0.
- Random regression:
  - Stimulus: 100 iterations of random a, b, c, d, s0, s1, in_valid=1, 10-time-unit period.
  - Response: every cycle, out equals the reference select of the inputs sampled LATENCY cycles earlier, and sel_q matches the sampled {s1,s0}.
- Reset mid-stream:
  - Stimulus: LATENCY=4 pipeline full, then rst_n pulsed low for 3 time units.
  - Response: out_valid stays 0 until 4 edges after the first new in_valid=1.
